// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_ctrl_fsm_pkg: mips_defs package shared by the controller, decoder and ALU.
package mips_defs;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_LUI  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_SLT  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_OR   = 4'b0110
  } alu_op_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;
  localparam logic [1:0] DST_RT    = 2'd0;
  localparam logic [1:0] DST_RD    = 2'd1;
  localparam logic [1:0] DST_RA    = 2'd2;
  localparam logic [1:0] WB_ALU    = 2'd0;
  localparam logic [1:0] WB_MEM    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;
endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: controller <-> datapath control bundle; master is the controller.
interface mc_ctrl_fsm_if;
  logic [31:0] instr;
  logic        equal;
  logic        pc_en;
  logic [1:0]  pc_src;
  logic        ir_en;
  logic [3:0]  alu_op;
  logic        alu_srcb;
  logic        ext_op;
  logic        reg_we;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic        mem_we;
  logic [2:0]  state_o;
  modport master (
    input  instr, equal,
    output pc_en, pc_src, ir_en, alu_op, alu_srcb, ext_op, reg_we, reg_dst, mem_to_reg, mem_we, state_o
  );
  modport slave (
    output instr, equal,
    input  pc_en, pc_src, ir_en, alu_op, alu_srcb, ext_op, reg_we, reg_dst, mem_to_reg, mem_we, state_o
  );
endinterface

// File: rtl/mc_ctrl_fsm_decode.sv
// mc_decode: combinational instruction classifier producing class flags and ALU op.
module mc_decode
  import mips_defs::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       is_rtype,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_beq,
  output logic       is_jal,
  output logic       is_jr,
  output logic       is_ori,
  output logic       is_lui,
  output logic       is_illegal,
  output logic [3:0] alu_op
);
  logic       r;
  logic [3:0] rtype_op;
  assign r          = op == OP_RTYPE;
  assign is_rtype   = r && (funct inside {FN_ADD, FN_SUB, FN_SLT, FN_SLTU, FN_SLL});
  assign is_jr      = r && funct == FN_JR;
  assign is_lw      = op == OP_LW;
  assign is_sw      = op == OP_SW;
  assign is_beq     = op == OP_BEQ;
  assign is_jal     = op == OP_JAL;
  assign is_ori     = op == OP_ORI;
  assign is_lui     = op == OP_LUI;
  assign is_illegal = !(is_rtype || is_jr || is_lw || is_sw || is_beq || is_jal || is_ori || is_lui);
  assign rtype_op   = funct == FN_SUB  ? ALU_SUB  :
                      funct == FN_SLT  ? ALU_SLT  :
                      funct == FN_SLTU ? ALU_SLTU :
                      funct == FN_SLL  ? ALU_SLL  : ALU_ADD;
  assign alu_op     = is_rtype ? rtype_op :
                      is_ori   ? ALU_OR   :
                      is_lui   ? ALU_LUI  :
                      is_beq   ? ALU_SUB  : ALU_ADD;
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS main controller (FETCH/DECODE/EXEC/MEM/WB).
// MC_CTRL_ILLEGAL_TRAP_EN: unrecognised instructions trap into HALT and raise illegal.
module mc_ctrl_fsm
  import mips_defs::*;
#(
  parameter int         RA_IDX      = 31,
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic clk,
  input  logic reset,
  mc_ctrl_fsm_if.master b
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic illegal
`endif
);
  if (RA_IDX < 0 || RA_IDX > 31) begin : g_ra_chk
    $error("RA_IDX must be a register index 0..31");
  end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam state_t ILL_NEXT = S_HALT;
`else
  localparam state_t ILL_NEXT = S_FETCH;
`endif
  state_t     state, nxt;
  logic       is_rtype, is_lw, is_sw, is_beq, is_jal, is_jr, is_ori, is_lui, is_illegal;
  logic [3:0] dec_alu_op;
  logic       f, x, m, w;
  logic       unused_instr;
  assign unused_instr = ^b.instr[25:6];
  mc_decode u_dec (
    .op        (b.instr[31:26]),
    .funct     (b.instr[5:0]),
    .is_rtype  (is_rtype),
    .is_lw     (is_lw),
    .is_sw     (is_sw),
    .is_beq    (is_beq),
    .is_jal    (is_jal),
    .is_jr     (is_jr),
    .is_ori    (is_ori),
    .is_lui    (is_lui),
    .is_illegal(is_illegal),
    .alu_op    (dec_alu_op)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= state_t'(RESET_STATE);
    else        state <= nxt;
  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: nxt = is_illegal ? ILL_NEXT : is_jal ? S_WB : S_EXEC;
      S_EXEC:   nxt = (is_lw || is_sw) ? S_MEM : (is_beq || is_jr) ? S_FETCH : S_WB;
      S_MEM:    nxt = is_lw ? S_WB : S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_FETCH;
    endcase
  end
  assign f = state == S_FETCH;
  assign x = state == S_EXEC;
  assign m = state == S_MEM;
  assign w = state == S_WB;
  // Enables are gated by reset so nothing is written while reset is held.
  always_comb begin
    b.state_o    = state;
    b.ir_en      = reset && f;
    b.pc_en      = reset && (f || (x && (is_jr || (is_beq && b.equal))) || (w && is_jal));
    b.pc_src     = (x && is_jr) ? PC_RS : (x && is_beq) ? PC_BRANCH : (w && is_jal) ? PC_JUMP : PC_PLUS4;
    b.alu_op     = x ? dec_alu_op : ALU_ADD;
    b.alu_srcb   = x && (is_ori || is_lui || is_lw || is_sw);
    b.ext_op     = x && (is_lw || is_sw || is_beq);
    b.reg_we     = reset && w;
    b.reg_dst    = !w ? DST_RT : is_jal ? DST_RA : is_rtype ? DST_RD : DST_RT;
    b.mem_to_reg = !w ? WB_ALU : is_jal ? WB_PC4 : is_lw ? WB_MEM : WB_ALU;
    b.mem_we     = reset && m && is_sw;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    illegal      = state == S_HALT;
`endif
  end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed plus random instruction streams checked against a per-instruction cycle model.
module tb_mc_ctrl_fsm;
  typedef enum int {C_R, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JR, C_JAL, C_ILL} cls_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic illegal_w;
  logic [19:0] act;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  mc_ctrl_fsm_if b ();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  mc_ctrl_fsm dut (.clk(clk), .reset(reset), .b(b), .illegal(illegal_w));
`else
  mc_ctrl_fsm dut (.clk(clk), .reset(reset), .b(b));
  assign illegal_w = 1'b0;
`endif
  assign act = {illegal_w, b.state_o, b.pc_en, b.pc_src, b.ir_en, b.alu_op, b.alu_srcb,
                b.ext_op, b.reg_we, b.reg_dst, b.mem_to_reg, b.mem_we};

  function automatic cls_t classify(logic [31:0] i);
    logic [5:0] op, fn;
    op = i[31:26];
    fn = i[5:0];
    if (op == 6'h00) return (fn inside {6'h20, 6'h22, 6'h2A, 6'h2B, 6'h00}) ? C_R : (fn == 6'h08) ? C_JR : C_ILL;
    case (op)
      6'h0D:   return C_ORI;
      6'h0F:   return C_LUI;
      6'h23:   return C_LW;
      6'h2B:   return C_SW;
      6'h04:   return C_BEQ;
      6'h03:   return C_JAL;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [3:0] exp_aluop(logic [31:0] i);
    cls_t c;
    c = classify(i);
    if (c == C_R)
      case (i[5:0])
        6'h20:   return 4'b0000;
        6'h22:   return 4'b0001;
        6'h2A:   return 4'b0100;
        6'h2B:   return 4'b0011;
        default: return 4'b0101;
      endcase
    return c == C_ORI ? 4'b0110 : c == C_LUI ? 4'b0010 : c == C_BEQ ? 4'b0001 : 4'b0000;
  endfunction

  // Expected outputs for instruction i while the controller is in step st (0..5).
  function automatic logic [19:0] expect_out(logic [31:0] i, int st, logic eq);
    cls_t c;
    logic pc_en, ir_en, srcb, ext, we, mwe, ill;
    logic [1:0] pc_src, dst, m2r;
    logic [3:0] alu;
    c = classify(i);
    {pc_en, ir_en, srcb, ext, we, mwe, ill} = '0;
    {pc_src, dst, m2r} = '0;
    alu = 4'b0000;
    if (st == 0) begin ir_en = 1'b1; pc_en = 1'b1; end
    if (st == 2) begin
      alu  = exp_aluop(i);
      srcb = c inside {C_ORI, C_LUI, C_LW, C_SW};
      ext  = c inside {C_LW, C_SW, C_BEQ};
      if (c == C_BEQ) begin pc_en = eq; pc_src = 2'd1; end
      if (c == C_JR) begin pc_en = 1'b1; pc_src = 2'd3; end
    end
    if (st == 3) mwe = c == C_SW;
    if (st == 4) begin
      we  = 1'b1;
      dst = c == C_R ? 2'd1 : c == C_JAL ? 2'd2 : 2'd0;
      m2r = c == C_LW ? 2'd1 : c == C_JAL ? 2'd2 : 2'd0;
      if (c == C_JAL) begin pc_en = 1'b1; pc_src = 2'd2; end
    end
    if (st == 5) ill = 1'b1;
    return {ill, st[2:0], pc_en, pc_src, ir_en, alu, srcb, ext, we, dst, m2r, mwe};
  endfunction

  task automatic check(string tag, logic [19:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  // Entered at posedge+1 in FETCH; leaves at posedge+1 after the instruction retires.
  task automatic run(string tag, logic [31:0] i, int eqmode);
    int seq[$];
    case (classify(i))
      C_R, C_ORI, C_LUI: seq = {0, 1, 2, 4};
      C_LW:              seq = {0, 1, 2, 3, 4};
      C_SW:              seq = {0, 1, 2, 3};
      C_BEQ, C_JR:       seq = {0, 1, 2};
      C_JAL:             seq = {0, 1, 4};
      default:           seq = {0, 1};
    endcase
    b.instr = i;
    foreach (seq[k]) begin
      b.equal = eqmode == 2 ? 1'($urandom) : eqmode[0];
      @(negedge clk);
      check($sformatf("%s c%0d", tag, k), expect_out(i, seq[k], b.equal));
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] rand_instr(int maxk);
    logic [31:0] r;
    logic [5:0] fns [5];
    fns = '{6'h20, 6'h22, 6'h2A, 6'h2B, 6'h00};
    r = $urandom;
    case ($urandom_range(0, maxk))
      0: r = {6'h00, r[25:6], fns[$urandom_range(0, 4)]};
      1: r[31:26] = 6'h0D;
      2: r[31:26] = 6'h0F;
      3: r[31:26] = 6'h23;
      4: r[31:26] = 6'h2B;
      5: r[31:26] = 6'h04;
      6: r = {6'h00, r[25:6], 6'h08};
      7: r[31:26] = 6'h03;
      default: r = r[0] ? {6'h3F, r[25:0]} : {6'h00, r[25:6], 6'h3F};
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] ri;
    b.instr = 32'h00221820;
    b.equal = 1'b0;
    #2;
    check("reset", 20'h0);
    @(posedge clk);
    #1;
    check("reset_hold", 20'h0);
    reset = 1'b1;
    run("add", 32'h00221820, 0);
    run("lw", 32'h8CA40008, 0);
    run("beq_eq1", 32'h10220004, 1);
    run("beq_eq0", 32'h10220004, 0);
    run("jal", 32'h0C000010, 0);
    run("sw", 32'hACA40008, 0);
    run("ori", 32'h34A4FFFF, 0);
    run("lui", 32'h3C041234, 0);
    run("jr", 32'h03E00008, 1);
    run("nop", 32'h00000000, 0);
    run("sub", 32'h00221822, 0);
    run("slt", 32'h0022182A, 0);
    run("sltu", 32'h0022182B, 0);
    b.instr = 32'hACA40008;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      check($sformatf("sw_pre c%0d", s), expect_out(b.instr, s, b.equal));
      if (s < 3) begin
        @(posedge clk);
        #1;
      end
    end
    #1 reset = 1'b0;
    #1 check("rst_mid_sw", 20'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int n = 0; n < 60; n++) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      ri = rand_instr(7);
`else
      ri = rand_instr(8);
`endif
      run($sformatf("rnd%0d", n), ri, 2);
    end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    b.instr = 32'hFC000000;
    for (int s = 0; s < 12; s++) begin
      @(negedge clk);
      check($sformatf("halt c%0d", s), expect_out(b.instr, s < 2 ? s : 5, b.equal));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    #1 check("halt_rst", 20'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    run("post_halt", 32'h00221820, 0);
`else
    run("ill3f", 32'hFC000000, 2);
    run("post_ill", 32'h00221820, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
